// File: rtl/vec_hazard_pipe_pkg.sv
// vec_pkg: shared defaults, lane/vector types and forwarding-select codes
// for the vector-lane hazard pipeline.
package vec_pkg;

    localparam int LANES  = 10;
    localparam int LANE_W = 16;
    localparam int VAW    = 3;

    typedef logic [LANE_W-1:0] vlane_t;
    typedef vlane_t [LANES-1:0] vvec_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/vec_hazard_pipe_if.sv
// vec_hazard_pipe_if: groups the decode inputs, execute/memory data and the
// hazard outputs of the vector pipeline. The lane mask signals exist only
// when VEC_LANE_MASK_EN is defined.
interface vec_hazard_pipe_if #(
    parameter int LANES  = vec_pkg::LANES,
    parameter int LANE_W = vec_pkg::LANE_W,
    parameter int VAW    = vec_pkg::VAW
);
    localparam int VW = LANES * LANE_W;

    logic [VAW-1:0] VRA1D;
    logic [VAW-1:0] VRA2D;
    logic           VUse1D;
    logic           VUse2D;
    logic [VAW-1:0] VWA3D;
    logic           VRegWriteD;
    logic           VMemtoRegD;
    logic [VW-1:0]  VD1D;
    logic [VW-1:0]  VD2D;
    logic           FlushE;
    logic [VW-1:0]  ALUVResultE;
    logic [VW-1:0]  ReadDataVM;
`ifdef VEC_LANE_MASK_EN
    logic [LANES-1:0] VMaskD;
    logic [LANES-1:0] VMaskW;
`endif
    logic [VW-1:0]  SrcVAE;
    logic [VW-1:0]  SrcVBE;
    logic [VW-1:0]  ALUVResultM;
    logic [VW-1:0]  WriteDataVM;
    logic [VW-1:0]  VResultW;
    logic [VAW-1:0] VWA3W;
    logic           VRegWriteW;
    logic [1:0]     ForwardVAE;
    logic [1:0]     ForwardVBE;
    logic           StallVD;
    logic           FlushVE;

    modport master (
`ifdef VEC_LANE_MASK_EN
        output VMaskD, input VMaskW,
`endif
        output VRA1D, VRA2D, VUse1D, VUse2D, VWA3D, VRegWriteD, VMemtoRegD,
        output VD1D, VD2D, FlushE, ALUVResultE, ReadDataVM,
        input  SrcVAE, SrcVBE, ALUVResultM, WriteDataVM, VResultW, VWA3W,
        input  VRegWriteW, ForwardVAE, ForwardVBE, StallVD, FlushVE
    );

    modport slave (
`ifdef VEC_LANE_MASK_EN
        input VMaskD, output VMaskW,
`endif
        input  VRA1D, VRA2D, VUse1D, VUse2D, VWA3D, VRegWriteD, VMemtoRegD,
        input  VD1D, VD2D, FlushE, ALUVResultE, ReadDataVM,
        output SrcVAE, SrcVBE, ALUVResultM, WriteDataVM, VResultW, VWA3W,
        output VRegWriteW, ForwardVAE, ForwardVBE, StallVD, FlushVE
    );

endinterface

// File: rtl/vec_pipe_reg.sv
// vec_pipe_reg: pipeline register with asynchronous active-low reset and a
// synchronous clear used to inject bubbles.
module vec_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // capture every edge; clear wins over data so a bubble is all zeros
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      q <= '0;
        else if (clear)  q <= '0;
        else             q <= d;
    end

endmodule

// File: rtl/vec_hazard_pipe.sv
// vec_hazard_pipe: vector-lane D->E->M->W pipeline with E-stage operand
// forwarding from M/W and load-use stall detection.
// Optional feature macro: VEC_LANE_MASK_EN (per-lane write mask carried
// down the pipe and gating forwarding lane by lane).
module vec_hazard_pipe #(
    parameter int LANES  = vec_pkg::LANES,
    parameter int LANE_W = vec_pkg::LANE_W,
    parameter int VAW    = vec_pkg::VAW
) (
    input logic            clk,
    input logic            reset,
    vec_hazard_pipe_if.slave bus
);
    import vec_pkg::*;

    localparam int VW   = LANES * LANE_W;
    localparam int DE_W = 3 * VAW + 2 + 2 * VW;
    localparam int EM_W = 2 * VW + VAW + 2;
    localparam int MW_W = 2 * VW + VAW + 2;

    logic [VAW-1:0]   ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
    logic             reg_write_e, mem_to_reg_e;
    logic             reg_write_m, mem_to_reg_m;
    logic             reg_write_w, mem_to_reg_w;
    logic [VW-1:0]    vd1_e, vd2_e, alu_m, wd_m, alu_w, rd_w, result_w;
    logic [VW-1:0]    src_a, src_b;
    logic [LANES-1:0] mask_m, mask_w;
    logic [1:0]       sel_a [LANES];
    logic [1:0]       sel_b [LANES];
    logic             stall, flush_ve;

    vec_pipe_reg #(.W(DE_W)) reg_de (
        .clk(clk), .reset(reset), .clear(flush_ve),
        .d({bus.VRA1D, bus.VRA2D, bus.VWA3D, bus.VRegWriteD, bus.VMemtoRegD, bus.VD1D, bus.VD2D}),
        .q({ra1_e, ra2_e, wa3_e, reg_write_e, mem_to_reg_e, vd1_e, vd2_e})
    );

    vec_pipe_reg #(.W(EM_W)) reg_em (
        .clk(clk), .reset(reset), .clear(1'b0),
        .d({bus.ALUVResultE, src_b, wa3_e, reg_write_e, mem_to_reg_e}),
        .q({alu_m, wd_m, wa3_m, reg_write_m, mem_to_reg_m})
    );

    vec_pipe_reg #(.W(MW_W)) reg_mw (
        .clk(clk), .reset(reset), .clear(1'b0),
        .d({alu_m, bus.ReadDataVM, wa3_m, reg_write_m, mem_to_reg_m}),
        .q({alu_w, rd_w, wa3_w, reg_write_w, mem_to_reg_w})
    );

`ifdef VEC_LANE_MASK_EN
    logic [LANES-1:0] mask_e;

    vec_pipe_reg #(.W(LANES)) mask_de (
        .clk(clk), .reset(reset), .clear(flush_ve), .d(bus.VMaskD), .q(mask_e)
    );
    vec_pipe_reg #(.W(LANES)) mask_em (
        .clk(clk), .reset(reset), .clear(1'b0), .d(mask_e), .q(mask_m)
    );
    vec_pipe_reg #(.W(LANES)) mask_mw (
        .clk(clk), .reset(reset), .clear(1'b0), .d(mask_m), .q(mask_w)
    );

    assign bus.VMaskW = mask_w;
`else
    assign mask_m = '1;
    assign mask_w = '1;
`endif

    assign result_w = mem_to_reg_w ? rd_w : alu_w;

    // per-lane forward select: M beats W, and a stage only forwards lanes it writes
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            sel_a[i] = FWD_RF;
            sel_b[i] = FWD_RF;
            if (reg_write_m && mask_m[i] && (wa3_m == ra1_e))
                sel_a[i] = FWD_M;
            else if (reg_write_w && mask_w[i] && (wa3_w == ra1_e))
                sel_a[i] = FWD_W;
            if (reg_write_m && mask_m[i] && (wa3_m == ra2_e))
                sel_b[i] = FWD_M;
            else if (reg_write_w && mask_w[i] && (wa3_w == ra2_e))
                sel_b[i] = FWD_W;
        end
    end

    // operand muxes; the unused 11 code falls back to the register-file value
    always_comb begin
        src_a = vd1_e;
        src_b = vd2_e;
        for (int i = 0; i < LANES; i++) begin
            case (sel_a[i])
                FWD_M:   src_a[i*LANE_W +: LANE_W] = alu_m[i*LANE_W +: LANE_W];
                FWD_W:   src_a[i*LANE_W +: LANE_W] = result_w[i*LANE_W +: LANE_W];
                default: ;
            endcase
            case (sel_b[i])
                FWD_M:   src_b[i*LANE_W +: LANE_W] = alu_m[i*LANE_W +: LANE_W];
                FWD_W:   src_b[i*LANE_W +: LANE_W] = result_w[i*LANE_W +: LANE_W];
                default: ;
            endcase
        end
    end

    // a load in E whose destination is read by D cannot be forwarded in time
    assign stall = reg_write_e & mem_to_reg_e &
                   ((bus.VUse1D & (bus.VRA1D == wa3_e)) |
                    (bus.VUse2D & (bus.VRA2D == wa3_e)));
    assign flush_ve = stall | bus.FlushE;

    assign bus.SrcVAE      = src_a;
    assign bus.SrcVBE      = src_b;
    assign bus.ALUVResultM = alu_m;
    assign bus.WriteDataVM = wd_m;
    assign bus.VResultW    = result_w;
    assign bus.VWA3W       = wa3_w;
    assign bus.VRegWriteW  = reg_write_w;
    assign bus.ForwardVAE  = sel_a[0];
    assign bus.ForwardVBE  = sel_b[0];
    assign bus.StallVD     = stall;
    assign bus.FlushVE     = flush_ve;

endmodule

// File: tb/tb_vec_hazard_pipe.sv
// tb_vec_hazard_pipe: directed self-checking bench for vec_hazard_pipe.
// Optional feature macro: VEC_LANE_MASK_EN (adds the lane-mask scenario).
module tb_vec_hazard_pipe;

    localparam int N  = 10;
    localparam int LW = 16;
    localparam int VW = N * LW;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    vec_hazard_pipe_if #(.LANES(N), .LANE_W(LW), .VAW(3)) bus ();

    vec_hazard_pipe #(.LANES(N), .LANE_W(LW), .VAW(3)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // advance one cycle and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one instruction in Decode
    task automatic set_d(input logic [2:0] ra1, input logic [2:0] ra2,
                         input logic u1, input logic u2, input logic [2:0] wa3,
                         input logic rw, input logic mtr,
                         input logic [VW-1:0] d1, input logic [VW-1:0] d2);
        bus.VRA1D      = ra1;
        bus.VRA2D      = ra2;
        bus.VUse1D     = u1;
        bus.VUse2D     = u2;
        bus.VWA3D      = wa3;
        bus.VRegWriteD = rw;
        bus.VMemtoRegD = mtr;
        bus.VD1D       = d1;
        bus.VD2D       = d2;
    endtask

    // empty the pipe with three bubbles
    task automatic drain();
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
        bus.ALUVResultE = '0;
        bus.ReadDataVM  = '0;
        bus.FlushE      = 1'b0;
        repeat (3) step();
    endtask

    // async reset mid-stream clears everything without a clock edge
    task automatic test_reset();
        drain();
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, '0, '0);
        step();
        bus.ALUVResultE = {N{16'h00AB}};
        set_d(3'd6, 3'd6, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, {N{16'h1111}}, {N{16'h2222}});
        step();
        total++;
        if (bus.ForwardVAE !== 2'b10) begin
            bad++;
            $display("[TB] FAIL pre_reset_fwd got=%b exp=%b", bus.ForwardVAE, 2'b10);
        end
        bus.ALUVResultE = '0;
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
        step();
        total++;
        if (bus.VResultW !== {N{16'h00AB}}) begin
            bad++;
            $display("[TB] FAIL pre_reset_resw got=%h exp=%h", bus.VResultW, {N{16'h00AB}});
        end
        total++;
        if (bus.WriteDataVM !== {N{16'h00AB}}) begin
            bad++;
            $display("[TB] FAIL pre_reset_wdm got=%h exp=%h", bus.WriteDataVM, {N{16'h00AB}});
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus.VRegWriteW !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_rwW got=%b exp=0", bus.VRegWriteW);
        end
        total++;
        if (bus.VResultW !== '0) begin
            bad++;
            $display("[TB] FAIL reset_resW got=%h exp=0", bus.VResultW);
        end
        total++;
        if (bus.WriteDataVM !== '0) begin
            bad++;
            $display("[TB] FAIL reset_wdM got=%h exp=0", bus.WriteDataVM);
        end
        total++;
        if (bus.VWA3W !== 3'd0) begin
            bad++;
            $display("[TB] FAIL reset_wa3W got=%h exp=0", bus.VWA3W);
        end
        total++;
        if (bus.StallVD !== 1'b0 || bus.FlushVE !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_hazard got=%b%b exp=00", bus.StallVD, bus.FlushVE);
        end
        repeat (2) step();
        #2;
        reset = 1'b1;
        step();
        total++;
        if (bus.ForwardVAE !== 2'b00 || bus.ForwardVBE !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_release_fwd got=%b/%b exp=00/00", bus.ForwardVAE, bus.ForwardVBE);
        end
    endtask

    // result in M forwards to the very next instruction
    task automatic test_fwd_m();
        logic [VW-1:0] alu;
        drain();
        alu = '0;
        alu[15:0] = 16'h1234;
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, '0, '0);
        step();
        bus.ALUVResultE = alu;
        set_d(3'd2, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, {N{16'hAAAA}}, {N{16'hBBBB}});
        step();
        total++;
        if (bus.ForwardVAE !== 2'b10) begin
            bad++;
            $display("[TB] FAIL fwd_m_sel got=%b exp=10", bus.ForwardVAE);
        end
        total++;
        if (bus.SrcVAE[15:0] !== 16'h1234 || bus.SrcVAE[31:16] !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL fwd_m_val got=%h exp=0000_1234", bus.SrcVAE[31:0]);
        end
        total++;
        if (bus.SrcVBE !== {N{16'hBBBB}}) begin
            bad++;
            $display("[TB] FAIL fwd_m_b_rf got=%h exp=%h", bus.SrcVBE, {N{16'hBBBB}});
        end
    endtask

    // two writers in a row: M wins; with one gap: W supplies the value
    task automatic test_fwd_w();
        drain();
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, '0, '0);
        step();
        bus.ALUVResultE = {N{16'h0001}};
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, '0, '0);
        step();
        bus.ALUVResultE = {N{16'h0002}};
        set_d(3'd7, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, {N{16'h4444}}, {N{16'h5555}});
        step();
        bus.ALUVResultE = '0;
        total++;
        if (bus.ForwardVBE !== 2'b10 || bus.SrcVBE[15:0] !== 16'h0002) begin
            bad++;
            $display("[TB] FAIL prio_m got=%b/%h exp=10/0002", bus.ForwardVBE, bus.SrcVBE[15:0]);
        end
        total++;
        if (bus.ForwardVAE !== 2'b00 || bus.SrcVAE !== {N{16'h4444}}) begin
            bad++;
            $display("[TB] FAIL prio_a_rf got=%b/%h exp=00/4444", bus.ForwardVAE, bus.SrcVAE[15:0]);
        end

        drain();
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, '0, '0);
        step();
        bus.ALUVResultE = {N{16'h0001}};
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
        step();
        bus.ALUVResultE = '0;
        set_d(3'd7, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, {N{16'h4444}}, {N{16'h5555}});
        step();
        total++;
        if (bus.ForwardVBE !== 2'b01 || bus.SrcVBE !== {N{16'h0001}}) begin
            bad++;
            $display("[TB] FAIL fwd_w got=%b/%h exp=01/0001", bus.ForwardVBE, bus.SrcVBE[15:0]);
        end
        total++;
        if (bus.VRegWriteW !== 1'b1 || bus.VWA3W !== 3'd3) begin
            bad++;
            $display("[TB] FAIL fwd_w_wb got=%b/%h exp=1/3", bus.VRegWriteW, bus.VWA3W);
        end
    endtask

    // load followed by a reader: one stall cycle, then W forwarding
    task automatic test_load_use();
        logic [VW-1:0] rd;
        drain();
        rd = '0;
        rd[9*LW +: LW] = 16'hBEEF;
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, '0, '0);
        step();
        set_d(3'd5, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, {N{16'h1111}}, '0);
        #1;
        total++;
        if (bus.StallVD !== 1'b1 || bus.FlushVE !== 1'b1) begin
            bad++;
            $display("[TB] FAIL lu_stall got=%b%b exp=11", bus.StallVD, bus.FlushVE);
        end
        step();
        bus.ReadDataVM = rd;
        #1;
        total++;
        if (bus.StallVD !== 1'b0 || bus.FlushVE !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lu_one_cycle got=%b%b exp=00", bus.StallVD, bus.FlushVE);
        end
        step();
        bus.ReadDataVM = '0;
        total++;
        if (bus.ForwardVAE !== 2'b01) begin
            bad++;
            $display("[TB] FAIL lu_sel got=%b exp=01", bus.ForwardVAE);
        end
        total++;
        if (bus.SrcVAE[9*LW +: LW] !== 16'hBEEF || bus.SrcVAE[15:0] !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL lu_val got=%h/%h exp=BEEF/0000", bus.SrcVAE[9*LW +: LW], bus.SrcVAE[15:0]);
        end
        total++;
        if (bus.VResultW !== rd) begin
            bad++;
            $display("[TB] FAIL lu_resw got=%h exp=%h", bus.VResultW, rd);
        end
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
        #1;
        total++;
        if (bus.StallVD !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lu_no_restall got=%b exp=0", bus.StallVD);
        end
    endtask

    // external flush turns the E writer into a bubble that never writes back
    task automatic test_flush();
        drain();
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, '0, '0);
        bus.FlushE = 1'b1;
        #1;
        total++;
        if (bus.FlushVE !== 1'b1 || bus.StallVD !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_comb got=%b%b exp=10", bus.FlushVE, bus.StallVD);
        end
        step();
        bus.FlushE = 1'b0;
        bus.ALUVResultE = {N{16'h5555}};
        set_d(3'd1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, {N{16'h2222}}, '0);
        step();
        bus.ALUVResultE = '0;
        total++;
        if (bus.ForwardVAE !== 2'b00 || bus.SrcVAE !== {N{16'h2222}}) begin
            bad++;
            $display("[TB] FAIL flush_nofwd got=%b/%h exp=00/2222", bus.ForwardVAE, bus.SrcVAE[15:0]);
        end
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
        step();
        total++;
        if (bus.VRegWriteW !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_rwW got=%b exp=0", bus.VRegWriteW);
        end
    endtask

`ifdef VEC_LANE_MASK_EN
    // only unmasked lanes forward; the rest keep the register-file operand
    task automatic test_mask();
        drain();
        bus.VMaskD = 10'b0000000001;
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, '0, '0);
        step();
        bus.VMaskD = '1;
        bus.ALUVResultE = {N{16'h7777}};
        set_d(3'd4, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, {N{16'h0A0A}}, '0);
        step();
        bus.ALUVResultE = '0;
        total++;
        if (bus.ForwardVAE !== 2'b10 || bus.SrcVAE[15:0] !== 16'h7777) begin
            bad++;
            $display("[TB] FAIL mask_lane0 got=%b/%h exp=10/7777", bus.ForwardVAE, bus.SrcVAE[15:0]);
        end
        for (int i = 1; i < N; i++) begin
            total++;
            if (bus.SrcVAE[i*LW +: LW] !== 16'h0A0A) begin
                bad++;
                $display("[TB] FAIL mask_lane%0d got=%h exp=0A0A", i, bus.SrcVAE[i*LW +: LW]);
            end
        end
    endtask
`endif

    // run every scenario in order, then report
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        set_d(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
        bus.FlushE      = 1'b0;
        bus.ALUVResultE = '0;
        bus.ReadDataVM  = '0;
`ifdef VEC_LANE_MASK_EN
        bus.VMaskD = '1;
`endif
        #12;
        reset = 1'b1;
        test_reset();
        test_fwd_m();
        test_fwd_w();
        test_load_use();
        test_flush();
`ifdef VEC_LANE_MASK_EN
        test_mask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_hazard_pipe.md
Name: vec_hazard_pipe

Overview:
- Parametrised vector-lane pipeline for the ARM-style 5-stage core. Generalises the fixed 10x16 vector path.
- Carries vector operands and results through D->E->M->W with control bits.
- Forwards vector operands in E from M and W.
- Detects vector load-use hazards, stalling D and bubbling E.
- Instantiated beside the scalar datapath; the scalar hazard unit ORs its stall/flush with ours.

Parameters:
LANES, 10, number of vector lanes
LANE_W, 16, bits per lane
VAW, 3, vector register address width (2**VAW registers)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
VRA1D  in  VAW  source-1 vector reg address, Decode
VRA2D  in  VAW  source-2 vector reg address, Decode
VUse1D  in  1  instruction in D reads source 1
VUse2D  in  1  instruction in D reads source 2
VWA3D  in  VAW  destination vector reg, Decode
VRegWriteD  in  1  D instruction writes a vector reg
VMemtoRegD  in  1  D instruction is a vector load
VD1D  in  LANES*LANE_W  register-file read data 1
VD2D  in  LANES*LANE_W  register-file read data 2
FlushE  in  1  external flush of E (taken branch)
ALUVResultE  in  LANES*LANE_W  vector ALU result, Execute
ReadDataVM  in  LANES*LANE_W  vector memory read data, Memory
SrcVAE  out  LANES*LANE_W  forwarded operand A, Execute
SrcVBE  out  LANES*LANE_W  forwarded operand B / store data, Execute
ALUVResultM  out  LANES*LANE_W  registered ALU result, Memory (address/forward)
WriteDataVM  out  LANES*LANE_W  registered store data, Memory
VResultW  out  LANES*LANE_W  writeback result
VWA3W  out  VAW  writeback destination
VRegWriteW  out  1  writeback enable
ForwardVAE  out  2  operand A select: 00 regfile, 01 W, 10 M
ForwardVBE  out  2  operand B select, same encoding
StallVD  out  1  stall F/D (load-use)
FlushVE  out  1  clear D->E register next edge

Behaviour:
- Packing: lane i occupies bits [i*LANE_W +: LANE_W] on every vector bus.
- Reset (reset=0, async): all pipeline registers clear to 0, including data, VWA3*, VRegWrite*, VMemtoReg*.
  - Consequences: VRegWriteW=0, VResultW=0, ForwardV*E=00, StallVD=0, FlushVE=0.
- D->E register captures VRA1D, VRA2D, VWA3D, VRegWriteD, VMemtoRegD, VD1D, VD2D every edge.
  - If FlushVE=1, it instead loads all zeros (bubble: VRegWriteE=0).
- E->M and M->W registers advance every edge, with no enable.
  - E->M captures ALUVResultE, SrcVBE, VWA3E, VRegWriteE, VMemtoRegE.
  - M->W captures ALUVResultM, ReadDataVM, VWA3M, VRegWriteM, VMemtoRegM.
- VResultW = VMemtoRegW ? ReadDataVW : ALUVResultW. Combinational from W registers.
- ForwardVAE (combinational):
  - 10 if VRegWriteM and VWA3M==VRA1E;
  - else 01 if VRegWriteW and VWA3W==VRA1E;
  - else 00.
  - M has priority over W.
  - ForwardVBE is identical, using VRA2E.
- SrcVAE/SrcVBE: 3:1 mux of {VD1E/VD2E, VResultW, ALUVResultM} per select.
  - Select 11 is illegal and never produced; the mux outputs VD*E.
- Forward M source is always ALUVResultM. Load data reaches E only via W after the stall.
- StallVD = VRegWriteE & VMemtoRegE & ((VUse1D & VRA1D==VWA3E) | (VUse2D & VRA2D==VWA3E)). Combinational.
- FlushVE = StallVD | FlushE.
- StallVD and FlushE together: bubble inserted once. The D instruction is held externally, then re-decoded.
- Back-to-back load-use: exactly one bubble per hazard. After the bubble, the load is in M, and W-forwarding covers it next cycle.
- Reset deasserted mid-stream: the pipeline restarts empty. There is no partial-state retention.

Optional Feature:
VEC_LANE_MASK_EN
- Defined:
  - Adds input VMaskD [LANES] and output VMaskW [LANES].
  - The mask is carried D->E->M->W with the other controls; a bubble clears it to 0.
  - Forwarding per lane: a lane forwards from M/W only if that stage's mask bit is 1. Otherwise the lane takes VD*E.
  - ForwardV*E reports the select for lane 0.
- Undefined: no extra ports; every lane behaves as mask bit 1.

Decomposition:
- Package vec_pkg holds:
  - LANES, LANE_W, VAW defaults;
  - typedef vlane_t = logic [LANE_W-1:0];
  - typedef vvec_t = vlane_t [LANES-1:0];
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One sub-module: vec_pipe_reg, a parametrised async-active-low-reset register with synchronous clear. Instantiated for the D->E, E->M and M->W registers.

Test Plan:
1. Reset: assert reset=0 mid-stream with nonzero data. All outputs go to 0 immediately, with no clock edge. After release, ForwardV*E=00.
2. M forward: ADD writes V2 with lane0=0x1234. The next instruction reads V2 as src1 → in E, ForwardVAE=10 and SrcVAE lane0=0x1234.
3. W forward + priority:
   - V3 written twice in a row (0x0001, then 0x0002), then a reader of V3 → ForwardVBE=10, value 0x0002.
   - With one gap instead → 01, value 0x0001.
4. Load-use: vector load to V5 (ReadDataVM lane9=0xBEEF), then a reader of V5 →
   - StallVD=1 and FlushVE=1 for exactly one cycle;
   - the reader then sees ForwardVAE=01 and SrcVAE lane9=0xBEEF.
5. Flush: FlushE=1 while a writer of V1 is in D → the E bubble has VRegWriteE=0. Three cycles later VRegWriteW=0 and no forwarding to V1 occurs.
6. Mask (VEC_LANE_MASK_EN): writer of V4 with VMaskD=10'b0000000001, then reader of V4 →
   - lane0 forwarded from M;
   - lanes 1-9 equal VD1E.
